// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types, widths and address-split helpers for the data cache
// Contents: state_t (IDLE/WRITEBACK/ALLOCATE), default geometry localparams,
//           and tag/index/word-select extraction functions.
// The extraction helpers take a zero-extended 64-bit address and a runtime index
// width, so the same functions serve any ADDR_W/NUM_LINES the top is built with;
// callers size-cast the result to their own field width.
package dcache_pkg;

  localparam int OFFSET_W       = 5;
  localparam int WORDS_PER_LINE = 8;
  localparam int ADDR_W_DEF     = 32;
  localparam int NUM_LINES_DEF  = 32;
  localparam int INDEX_W        = $clog2(NUM_LINES_DEF);
  localparam int TAG_W          = ADDR_W_DEF - OFFSET_W - INDEX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  // Word within the line; byte offset bits [1:0] are discarded.
  function automatic logic [2:0] addr_word(input logic [63:0] addr);
    return 3'((addr >> 2) & 64'(WORDS_PER_LINE - 1));
  endfunction

  function automatic logic [63:0] addr_index(input logic [63:0] addr, input int index_w);
    return (addr >> OFFSET_W) & ((64'd1 << index_w) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int index_w);
    return addr >> (OFFSET_W + index_w);
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// rtl/dcache_line_array.sv - valid/dirty/tag/data storage for the direct-mapped cache
// Ports:
//   clk_i, rst_i            clock, asynchronous active-low clear of valid/dirty
//   rd_idx -> rd_valid/rd_dirty/rd_tag/rd_line   combinational read port
//   word_we/word_idx/word_sel/word_data          32-bit store-hit write, sets dirty
//   line_we/line_idx/line_tag/line_data          whole-line fill, sets valid, clears dirty
// Tag and data arrays are deliberately left unreset; valid gates their use.
module dcache_line_array #(
  parameter int NUM_LINES = dcache_pkg::NUM_LINES_DEF,
  parameter int INDEX_W   = dcache_pkg::INDEX_W,
  parameter int TAG_W     = dcache_pkg::TAG_W,
  parameter int LINE_W    = dcache_pkg::WORDS_PER_LINE * 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [LINE_W-1:0]  rd_line,
  input  logic               word_we,
  input  logic [INDEX_W-1:0] word_idx,
  input  logic [2:0]         word_sel,
  input  logic [31:0]        word_data,
  input  logic               line_we,
  input  logic [INDEX_W-1:0] line_idx,
  input  logic [TAG_W-1:0]   line_tag,
  input  logic [LINE_W-1:0]  line_data
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we) begin
      valid_q[line_idx] <= 1'b1;
      dirty_q[line_idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[word_idx] <= 1'b1;
    end
  end

  // Fill and store-hit never coincide: fills happen in ALLOCATE, stores in IDLE.
  always_ff @(posedge clk_i) begin
    if (line_we) begin
      tag_q[line_idx]  <= line_tag;
      data_q[line_idx] <= line_data;
    end else if (word_we) begin
      data_q[word_idx][{word_sel, 5'b00000} +: 32] <= word_data;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-back write-allocate data cache controller
// Ports:
//   clk_i, rst_i                       clock, asynchronous active-low reset
//   cpu_req_i/cpu_we_i/cpu_addr_i/cpu_wdata_i   MEM-stage access (held while stalled)
//   cpu_rdata_o                        load data, same cycle on hit, zero otherwise
//   cpu_stall_o                        freezes the pipeline while a miss is serviced
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o   line request to memory (registered)
//   mem_ack_i/mem_rdata_i              one-cycle completion, fill data valid with ack
// Optional (macro DCACHE_STATS_EN): hit_cnt_o, miss_cnt_o saturating counters.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int NUM_LINES = NUM_LINES_DEF,
  parameter int LINE_W    = WORDS_PER_LINE * 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_rdata_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int INDEX_BITS = $clog2(NUM_LINES);
  localparam int TAG_BITS   = ADDR_W - OFFSET_W - INDEX_BITS;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic [2:0]            wsel;

  assign idx  = INDEX_BITS'(addr_index(64'(cpu_addr_i), INDEX_BITS));
  assign tag  = TAG_BITS'(addr_tag(64'(cpu_addr_i), INDEX_BITS));
  assign wsel = addr_word(64'(cpu_addr_i));

  logic                  rd_valid;
  logic                  rd_dirty;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [LINE_W-1:0]     rd_line;

  state_t                state_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic [LINE_W-1:0]     mem_wdata_q;
  // The fill target is latched so it survives the CPU dropping its request mid-miss.
  logic [INDEX_BITS-1:0] miss_idx_q;
  logic [TAG_BITS-1:0]   miss_tag_q;

  logic hit;
  logic word_we;
  logic line_we;

  assign hit     = cpu_req_i & rd_valid & (rd_tag == tag);
  assign word_we = (state_q == IDLE) & hit & cpu_we_i;
  assign line_we = (state_q == ALLOCATE) & mem_ack_i;

  assign cpu_rdata_o = hit ? rd_line[{wsel, 5'b00000} +: 32] : 32'd0;
  assign cpu_stall_o = (state_q != IDLE) | (cpu_req_i & ~hit);

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

  dcache_line_array #(
    .NUM_LINES (NUM_LINES),
    .INDEX_W   (INDEX_BITS),
    .TAG_W     (TAG_BITS),
    .LINE_W    (LINE_W)
  ) u_lines (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rd_idx    (idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .word_we   (word_we),
    .word_idx  (idx),
    .word_sel  (wsel),
    .word_data (cpu_wdata_i),
    .line_we   (line_we),
    .line_idx  (miss_idx_q),
    .line_tag  (miss_tag_q),
    .line_data (mem_rdata_i)
  );

  // Memory-side outputs are loaded on the transition into a state and held
  // unchanged until that state's ack, which keeps the handshake stable.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      miss_idx_q  <= '0;
      miss_tag_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cpu_req_i && !hit) begin
            miss_idx_q <= idx;
            miss_tag_q <= tag;
            mem_req_q  <= 1'b1;
            if (rd_valid && rd_dirty) begin
              state_q     <= WRITEBACK;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {rd_tag, idx, {OFFSET_W{1'b0}}};
              mem_wdata_q <= rd_line;
            end else begin
              state_q     <= ALLOCATE;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= {tag, idx, {OFFSET_W{1'b0}}};
              mem_wdata_q <= '0;
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack_i) begin
            state_q     <= ALLOCATE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {miss_tag_q, miss_idx_q, {OFFSET_W{1'b0}}};
            mem_wdata_q <= '0;
          end
        end
        ALLOCATE: begin
          if (mem_ack_i) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  // replay_q marks the first IDLE cycle after a fill, whose hit is the
  // re-execution of an access already counted as a miss.
  logic        replay_q;
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      replay_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (line_we) begin
        replay_q <= 1'b1;
      end else if (state_q == IDLE) begin
        replay_q <= 1'b0;
      end
      if ((state_q == IDLE) && hit && !replay_q && (hit_cnt_q != '1)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if ((state_q == IDLE) && cpu_req_i && !hit && (miss_cnt_q != '1)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - self-checking bench for dcache_controller
// Directed table of accesses, hand sequences for reset-mid-fill and dropped
// request, then randomized accesses checked against a behavioural cache model.
// Optional macro DCACHE_STATS_EN also connects and checks hit_cnt_o/miss_cnt_o.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_wdata_i;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o;
  logic         mem_ack_i;
  logic [255:0] mem_rdata_i;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  dcache_controller dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o   (hit_cnt),
    .miss_cnt_o  (miss_cnt)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int lat    = 3;

  // ---------------- backing memory (what the DUT talks to) ----------------
  logic [255:0] bmem [logic [31:0]];
  logic [31:0]  req_addr_q [$];
  logic         req_we_q   [$];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return 32'h1111_0000 + (a - 32'h40);
  endfunction

  function automatic logic [255:0] init_line(input logic [31:0] la);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = init_word(la + 32'(i * 4));
    return l;
  endfunction

  initial begin
    int cnt;
    cnt = 0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      if (mem_req_o) begin
        cnt++;
        if (cnt >= lat) begin
          cnt = 0;
          mem_ack_i = 1'b1;
          req_addr_q.push_back(mem_addr_o);
          req_we_q.push_back(mem_we_o);
          if (mem_we_o) bmem[mem_addr_o] = mem_wdata_o;
          else mem_rdata_i = bmem.exists(mem_addr_o) ? bmem[mem_addr_o] : init_line(mem_addr_o);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // ---------------- reference model: cache semantics at word level ----------------
  logic        m_valid [32];
  logic        m_dirty [32];
  int unsigned m_tag   [32];
  logic [31:0] m_word  [32][8];
  logic [31:0] rmem    [logic [31:0]];

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : init_word(a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  task automatic model_access(input logic [31:0] a, input logic we, input logic [31:0] wd,
                              input int l, output int exp_stall, output logic [31:0] exp_rd,
                              output int nreq, output logic [31:0] r0, output logic w0,
                              output logic [31:0] r1);
    int unsigned idx, tg, w;
    logic [31:0] base, vic;
    idx  = (a / 32) % 32;
    tg   = a / 1024;
    w    = (a / 4) % 8;
    base = a & ~32'd31;
    exp_stall = 0; nreq = 0; r0 = '0; w0 = 1'b0; r1 = '0;
    if (!(m_valid[idx] && m_tag[idx] == tg)) begin
      exp_stall = l + 1;
      if (m_valid[idx] && m_dirty[idx]) begin
        vic = 32'(m_tag[idx] * 1024 + idx * 32);
        for (int i = 0; i < 8; i++) rmem[vic + 32'(i * 4)] = m_word[idx][i];
        exp_stall += l;
        nreq = 2; r0 = vic; w0 = 1'b1; r1 = base;
      end else begin
        nreq = 1; r0 = base; w0 = 1'b0;
      end
      for (int i = 0; i < 8; i++) m_word[idx][i] = ref_word(base + 32'(i * 4));
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tg;
    end
    if (we) begin
      m_word[idx][w] = wd;
      m_dirty[idx]   = 1'b1;
    end
    exp_rd = m_word[idx][w];
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the access has completed.
  task automatic access(input logic [31:0] a, input logic we, input logic [31:0] wd,
                        output int stalls, output logic [31:0] rd, output logic timeout);
    cpu_req_i   = 1'b1;
    cpu_we_i    = we;
    cpu_addr_i  = a;
    cpu_wdata_i = wd;
    stalls  = 0;
    timeout = 1'b0;
    @(negedge clk_i);
    while (cpu_stall_o) begin
      stalls++;
      if (stalls > 100) begin
        timeout = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    rd = cpu_rdata_o;
    @(posedge clk_i);
    #1;
    cpu_req_i = 1'b0;
  endtask

  task automatic run_check(input string nm, input logic [31:0] a, input logic we,
                           input logic [31:0] wd, input int exp_stall, input logic [31:0] exp_rd,
                           input int exp_nreq, input logic [31:0] r0, input logic w0,
                           input logic [31:0] r1);
    int st;
    logic [31:0] rd;
    logic to;
    req_addr_q.delete();
    req_we_q.delete();
    access(a, we, wd, st, rd, to);
    chk({nm, "_timeout"}, 256'(to), 256'(1'b0));
    chk({nm, "_stalls"}, 256'(st), 256'(exp_stall));
    if (!we) chk({nm, "_rdata"}, 256'(rd), 256'(exp_rd));
    chk({nm, "_nreq"}, 256'(req_addr_q.size()), 256'(exp_nreq));
    if (exp_nreq > 0 && req_addr_q.size() > 0)
      chk({nm, "_req0"}, 256'({req_addr_q[0], req_we_q[0]}), 256'({r0, w0}));
    if (exp_nreq > 1 && req_addr_q.size() > 1)
      chk({nm, "_req1"}, 256'({req_addr_q[1], req_we_q[1]}), 256'({r1, 1'b0}));
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [7:0]  stalls;
    logic [31:0] rd;
    logic [1:0]  nreq;
    logic [31:0] r0;
    logic        w0;
    logic [31:0] r1;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int es, nr;
    logic [31:0] er, a0, a1, wd;
    logic ew, we;
    logic [255:0] ln;
    int l;

    vecs[0] = '{32'h40,  1'b0, 32'h0,         8'd4, 32'h1111_0000, 2'd1, 32'h40, 1'b0, 32'h0};
    vecs[1] = '{32'h44,  1'b1, 32'hDEAD_BEEF, 8'd0, 32'h0,         2'd0, 32'h0,  1'b0, 32'h0};
    vecs[2] = '{32'h44,  1'b0, 32'h0,         8'd0, 32'hDEAD_BEEF, 2'd0, 32'h0,  1'b0, 32'h0};
    vecs[3] = '{32'h440, 1'b0, 32'h0,         8'd7, 32'h1111_0400, 2'd2, 32'h40, 1'b1, 32'h440};
    vecs[4] = '{32'h84,  1'b1, 32'h1234_5678, 8'd4, 32'h0,         2'd1, 32'h80, 1'b0, 32'h0};
    vecs[5] = '{32'h84,  1'b0, 32'h0,         8'd0, 32'h1234_5678, 2'd0, 32'h0,  1'b0, 32'h0};
    vecs[6] = '{32'h80,  1'b0, 32'h0,         8'd0, 32'h1111_0040, 2'd0, 32'h0,  1'b0, 32'h0};
    vecs[7] = '{32'h9C,  1'b0, 32'h0,         8'd0, 32'h1111_005C, 2'd0, 32'h0,  1'b0, 32'h0};

    rst_i = 1'b0;
    cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
    model_reset();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_mem_req",   256'(mem_req_o),   256'(1'b0));
    chk("rst_mem_we",    256'(mem_we_o),    256'(1'b0));
    chk("rst_mem_addr",  256'(mem_addr_o),  256'(32'h0));
    chk("rst_mem_wdata", mem_wdata_o,       256'(0));
    chk("rst_stall",     256'(cpu_stall_o), 256'(1'b0));
    chk("rst_rdata",     256'(cpu_rdata_o), 256'(32'h0));
`ifdef DCACHE_STATS_EN
    chk("rst_hit_cnt",  256'(hit_cnt),  256'(0));
    chk("rst_miss_cnt", 256'(miss_cnt), 256'(0));
`endif
    @(posedge clk_i); #1;
    rst_i = 1'b1;

    // Directed table.
    lat = 3;
    for (int i = 0; i < 8; i++) begin
      model_access(vecs[i].addr, vecs[i].we, vecs[i].wdata, 3, es, er, nr, a0, ew, a1);
      run_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].we, vecs[i].wdata,
                int'(vecs[i].stalls), vecs[i].rd, int'(vecs[i].nreq), vecs[i].r0,
                vecs[i].w0, vecs[i].r1);
      if (i == 3) begin
        chk("wb_line_exists", 256'(bmem.exists(32'h40)), 256'(1));
        ln = bmem.exists(32'h40) ? bmem[32'h40] : '0;
        chk("wb_word0", 256'(ln[31:0]),    256'(32'h1111_0000));
        chk("wb_word1", 256'(ln[63:32]),   256'(32'hDEAD_BEEF));
        chk("wb_word7", 256'(ln[255:224]), 256'(32'h1111_001C));
`ifdef DCACHE_STATS_EN
        chk("stats_hit_cnt",  256'(hit_cnt),  256'(2));
        chk("stats_miss_cnt", 256'(miss_cnt), 256'(2));
`endif
      end
    end

    // Reset asserted while a fill is outstanding.
    lat = 50;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h1000; cpu_wdata_i = '0;
    repeat (3) @(negedge clk_i);
    chk("alloc_req_pending", 256'({mem_req_o, mem_we_o, mem_addr_o}), 256'({1'b1, 1'b0, 32'h1000}));
    #2;
    rst_i = 1'b0;
    #1;
    chk("async_rst_req", 256'(mem_req_o), 256'(1'b0));
    chk("async_rst_addr", 256'(mem_addr_o), 256'(32'h0));
    cpu_req_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    lat = 3;
    model_reset();
    model_access(32'h40, 1'b0, 32'h0, 3, es, er, nr, a0, ew, a1);
    run_check("post_rst_40", 32'h40, 1'b0, 32'h0, 4, 32'h1111_0000, 1, 32'h40, 1'b0, 32'h0);
    model_access(32'h44, 1'b0, 32'h0, 3, es, er, nr, a0, ew, a1);
    run_check("post_rst_44", 32'h44, 1'b0, 32'h0, 0, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, 32'h0);
    model_access(32'h84, 1'b0, 32'h0, 3, es, er, nr, a0, ew, a1);
    run_check("post_rst_84", 32'h84, 1'b0, 32'h0, 4, 32'h1111_0044, 1, 32'h80, 1'b0, 32'h0);

    // Store request withdrawn mid-miss: fill completes, store is never merged.
    model_access(32'h1084, 1'b0, 32'h0, 3, es, er, nr, a0, ew, a1);
    cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h1084; cpu_wdata_i = 32'hCAFE_F00D;
    repeat (2) @(negedge clk_i);
    @(posedge clk_i); #1;
    cpu_req_i = 1'b0;
    begin
      int n;
      n = 0;
      while (mem_req_o && n < 20) begin
        @(negedge clk_i);
        n++;
      end
      chk("drop_fill_done", 256'(mem_req_o), 256'(1'b0));
    end
    @(posedge clk_i); #1;
    run_check("drop_1084", 32'h1084, 1'b0, 32'h0, 0, 32'h1111_1044, 0, 32'h0, 1'b0, 32'h0);

    // Randomized accesses against the model.
    for (int k = 0; k < 200; k++) begin
      logic [31:0] ra;
      l  = int'($urandom_range(1, 4));
      ra = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 5) |
           (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      lat = l;
      model_access(ra, we, wd, l, es, er, nr, a0, ew, a1);
      run_check($sformatf("rnd%0d", k), ra, we, wd, es, er, nr, a0, ew, a1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
